aui_blk_gen_ctrl: RTL
=====================

Name: aui_blk_gen_ctrl

Overview:
Sequencing controller for the 257-bit AUI LFSR block generator. Captures a run configuration on start and loads the generator seed. Issues one-cycle generate enables in bursts with optional idle gaps. Buffers generated blocks in a 2-entry skid buffer and presents them downstream on a valid/ready stream with full throughput under backpressure. Sits between the test/config register bank and the 257b block lane feeding the AUI transmit path.

Parameters:
BLK_W, 257, block width (fixed by the AUI 257b format).
BURST_W, 16, width of burst-length configuration.
GAP_W, 8, width of inter-burst gap configuration.
CNT_W, 32, width of the accepted-block counter.

Ports:
clk  in  1  clock
rst  in  1  reset: asynchronous, active-high
start  in  1  begin run; sampled only in IDLE
stop  in  1  abort run; sampled in SEED/RUN/GAP
cfg_continuous  in  1  1 = repeat bursts until stop; 0 = single burst
cfg_burst_len  in  BURST_W  blocks per burst
cfg_gap_len  in  GAP_W  idle cycles between bursts (continuous mode)
cfg_seed  in  BLK_W  generator seed
gen_load  out  1  load gen_seed into generator this cycle
gen_seed  out  BLK_W  seed value (registered, captured at start)
gen_en  out  1  request one block from generator
gen_data  in  BLK_W  generated block
gen_valid  in  1  gen_data valid; exactly 1 cycle after gen_en
blk_data  out  BLK_W  downstream block
blk_valid  out  1  downstream valid
blk_ready  in  1  downstream ready
busy  out  1  state != IDLE
done  out  1  1-cycle pulse: single burst fully delivered
aborted  out  1  1-cycle pulse: stop-initiated drain complete
blk_cnt  out  CNT_W  accepted handshakes since last start; wraps
proto_err  out  1  sticky: gen_valid with no outstanding gen_en; cleared on start

Behaviour:
- Reset: state IDLE, every output 0, buffer empty, gen_seed 0, blk_cnt 0, proto_err 0.
- States: IDLE, SEED, RUN, GAP, DRAIN.
- IDLE: start=1 -> SEED. Capture cfg_* into shadow registers. A zero cfg_seed is replaced by 1 (avoids LFSR lockup). Clear blk_cnt, proto_err and the issued counter. stop is ignored in IDLE, so start wins if both are high.
- SEED: gen_load=1 for exactly one cycle, then RUN. If shadow burst_len == 0, go to DRAIN instead.
- RUN:
  - gen_en = 1 iff issued < burst_len AND (occ + inflight - pop) < 2, where pop = blk_valid & blk_ready and occ = buffer entries (0..2).
  - Each gen_en increments issued.
  - On the issue making issued == burst_len: continuous -> GAP (gap_len > 0) or stay in RUN with issued cleared (gap_len == 0); otherwise -> DRAIN.
- GAP: gen_en=0 for gap_len cycles, then RUN with issued cleared. The buffer keeps draining throughout.
- DRAIN: no issues. When inflight == 0 and occ == 0 -> IDLE, pulsing done (normal end) or aborted (stop-initiated).
- stop in SEED/RUN/GAP -> DRAIN next cycle; an issue in the same cycle still completes. No reseed on subsequent bursts; only start reloads the seed.
- Latency: start in cycle 0 -> gen_load cycle 1 -> first gen_en cycle 2 -> gen_valid cycle 3 -> blk_valid cycle 4.
- Buffer: FIFO order. A write on gen_valid and a pop may occur in the same cycle. blk_data/blk_valid are held stable while blk_valid & !blk_ready. Overflow is impossible under the gen_en rule.
- blk_cnt increments on every pop and wraps at 2^CNT_W.
- gen_valid with inflight == 0 sets proto_err; that data is dropped.
- start while busy is ignored. Async reset mid-run flushes the buffer and discards inflight data.

Decomposition:
- Package aui_blk_pkg:
  - BLK_W
  - blk_t (logic [BLK_W-1:0])
  - ctrl_state_e enum
  - LFSR_SAFE_SEED = 257'h1
- Sub-module blk_skid_buf: 2-entry valid/ready buffer with occ output, instantiated once.

Test Plan:
- Single burst: seed 0x5, len 4, blk_ready=1 -> gen_load at cycle 1; 4 consecutive blk_valid cycles 4..7 matching the reference LFSR sequence; done at cycle 8; blk_cnt=4.
- Backpressure: len 8, blk_ready toggling 1-0 -> no data lost or duplicated; occ never >2; blk_data stable while stalled; blk_cnt=8; single done.
- Continuous: len 3, gap 2 -> pattern of 3 gen_en, 2 idle, repeat; stop after 2 bursts -> aborted pulse after drain; no done; busy falls same cycle.
- Edge configs: seed 0 -> gen_seed=1. len 0 -> done 2 cycles after SEED, no blk_valid. gap 0 -> gen_en continuous across burst boundary.
- Async reset asserted mid-RUN with buffer full -> all outputs 0 immediately; a new start afterwards yields a fresh sequence from the seed.
- Spurious gen_valid in IDLE -> proto_err=1 sticky, no blk_valid; next start clears it.

Source files
------------

// File: rtl/aui_blk_pkg.sv
// ---------------------------------------------------------------------------
// aui_blk_pkg
// Shared types and constants for the AUI 257b block generator controller.
//   BLK_W          : block width, fixed by the AUI 257b format
//   blk_t          : one 257b block
//   ctrl_state_e   : sequencing FSM states
//   LFSR_SAFE_SEED : substitute for an all-zero seed (an LFSR locks at zero)
// ---------------------------------------------------------------------------
package aui_blk_pkg;

  localparam int BLK_W = 257;

  typedef logic [BLK_W-1:0] blk_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_GAP,
    ST_DRAIN
  } ctrl_state_e;

  localparam blk_t LFSR_SAFE_SEED = 257'h1;

  // An all-zero LFSR state never leaves zero, so it is swapped for a safe one.
  function automatic blk_t safe_seed(input blk_t seed);
    return (seed == '0) ? LFSR_SAFE_SEED : seed;
  endfunction

endpackage

// File: rtl/blk_skid_buf.sv
// ---------------------------------------------------------------------------
// blk_skid_buf
// Two-entry FIFO between the block generator and the downstream block lane.
// Lets a write and a pop happen in the same cycle, so a stalled consumer
// never costs throughput once it releases.
//   clk, rst  : clock, asynchronous active-high reset (flushes the buffer)
//   wr_en     : write wr_data this cycle
//   wr_data   : block to store
//   rd_valid  : head entry available
//   rd_ready  : consumer accepts the head entry this cycle
//   rd_data   : head entry (0 while empty), stable while stalled
//   occ       : current number of stored entries (0..2)
// ---------------------------------------------------------------------------
module blk_skid_buf
  import aui_blk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  blk_t       wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output blk_t       rd_data,
  output logic [1:0] occ
);

  blk_t       mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] occ_q;
  logic       push;
  logic       pop;

  assign rd_valid = (occ_q != 2'd0);
  assign pop      = rd_valid && rd_ready;
  // A write into a full buffer is only legal when the head leaves at once.
  assign push     = wr_en && ((occ_q != 2'd2) || pop);
  assign occ      = occ_q;

  // Gate the head so the lane reads zero while empty, including after reset.
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; occupancy is reset and
  // the output is gated, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/aui_blk_gen_ctrl.sv
// ---------------------------------------------------------------------------
// aui_blk_gen_ctrl
// Sequencing controller for the 257b AUI LFSR block generator. On start it
// captures the run configuration, loads the generator seed, then issues
// one-cycle generate enables in bursts separated by optional idle gaps.
// Generated blocks pass through a 2-entry skid buffer onto a valid/ready lane.
//   clk, rst         : clock, asynchronous active-high reset
//   start / stop     : begin run (IDLE only) / abort run (SEED, RUN, GAP)
//   cfg_continuous   : 1 = repeat bursts until stop, 0 = one burst
//   cfg_burst_len    : blocks per burst
//   cfg_gap_len      : idle cycles between bursts in continuous mode
//   cfg_seed         : generator seed (zero is replaced by 1)
//   gen_load/gen_seed: load seed into the generator / captured seed
//   gen_en           : request one block (data returns the next cycle)
//   gen_data/valid   : generated block and its strobe
//   blk_data/valid/ready : downstream block lane
//   busy             : controller not idle
//   done / aborted   : one-cycle end pulses (normal / stop-initiated)
//   blk_cnt          : accepted downstream handshakes since last start
//   proto_err        : sticky, gen_valid seen with no request outstanding
// ---------------------------------------------------------------------------
module aui_blk_gen_ctrl
  import aui_blk_pkg::*;
#(
  parameter int BURST_W = 16,
  parameter int GAP_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_continuous,
  input  logic [BURST_W-1:0] cfg_burst_len,
  input  logic [GAP_W-1:0]   cfg_gap_len,
  input  logic [BLK_W-1:0]   cfg_seed,
  output logic               gen_load,
  output logic [BLK_W-1:0]   gen_seed,
  output logic               gen_en,
  input  logic [BLK_W-1:0]   gen_data,
  input  logic               gen_valid,
  output logic [BLK_W-1:0]   blk_data,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [CNT_W-1:0]   blk_cnt,
  output logic               proto_err
);

  ctrl_state_e        state_q;
  logic               cont_q;
  logic [BURST_W-1:0] burst_len_q;
  logic [GAP_W-1:0]   gap_len_q;
  logic [BURST_W-1:0] issued_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               inflight_q;   // a gen_en was issued last cycle
  logic               stop_seen_q;  // current drain was caused by stop

  logic [1:0] occ;
  logic       pop;
  logic       buf_wr;
  logic [2:0] pending;
  logic       issue_last;
  logic       drain_done;
  logic       start_acc;

  // Skid buffer; data arriving with no request outstanding is dropped.
  assign buf_wr = gen_valid && inflight_q;

  blk_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (buf_wr),
    .wr_data  (gen_data),
    .rd_valid (blk_valid),
    .rd_ready (blk_ready),
    .rd_data  (blk_data),
    .occ      (occ)
  );

  assign pop       = blk_valid && blk_ready;
  assign start_acc = (state_q == ST_IDLE) && start;
  assign busy      = (state_q != ST_IDLE);
  assign gen_load  = (state_q == ST_SEED);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave a latch behind.
  always_comb begin
    // Entries the buffer will hold once this cycle's pop and the pending
    // return settle; issuing only while this is below 2 rules out overflow
    // and still sustains one block per cycle when the consumer is ready.
    pending    = 3'(occ) + 3'(inflight_q) - 3'(pop);
    gen_en     = 1'b0;
    issue_last = 1'b0;
    if (state_q == ST_RUN && issued_q < burst_len_q && pending < 3'd2) begin
      gen_en     = 1'b1;
      issue_last = ((issued_q + 1'b1) == burst_len_q);
    end
    // Exit on the cycle the final block is popped, so done follows directly.
    drain_done = !inflight_q && ((occ == 2'd0) || (occ == 2'd1 && pop));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cont_q      <= 1'b0;
      burst_len_q <= '0;
      gap_len_q   <= '0;
      issued_q    <= '0;
      gap_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      stop_seen_q <= 1'b0;
      gen_seed    <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      blk_cnt     <= '0;
      proto_err   <= 1'b0;
    end else begin
      done       <= 1'b0;
      aborted    <= 1'b0;
      inflight_q <= gen_en;

      if (start_acc)  blk_cnt <= '0;
      else if (pop)   blk_cnt <= blk_cnt + 1'b1;

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_SEED;
            cont_q      <= cfg_continuous;
            burst_len_q <= cfg_burst_len;
            gap_len_q   <= cfg_gap_len;
            gen_seed    <= safe_seed(cfg_seed);
            issued_q    <= '0;
            stop_seen_q <= 1'b0;
            proto_err   <= 1'b0;
          end
        end

        ST_SEED: begin
          if (stop) begin
            state_q     <= ST_DRAIN;
            stop_seen_q <= 1'b1;
          end else if (burst_len_q == '0) begin
            state_q <= ST_DRAIN;
          end else begin
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (gen_en) issued_q <= issued_q + 1'b1;
          if (stop) begin
            state_q     <= ST_DRAIN;
            stop_seen_q <= 1'b1;
          end else if (issue_last) begin
            if (!cont_q) begin
              state_q <= ST_DRAIN;
            end else if (gap_len_q != '0) begin
              state_q   <= ST_GAP;
              gap_cnt_q <= gap_len_q;
            end else begin
              // Back-to-back bursts: restart the count without leaving RUN.
              issued_q <= '0;
            end
          end
        end

        ST_GAP: begin
          if (stop) begin
            state_q     <= ST_DRAIN;
            stop_seen_q <= 1'b1;
          end else if (gap_cnt_q == GAP_W'(1)) begin
            state_q  <= ST_RUN;
            issued_q <= '0;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end

        ST_DRAIN: begin
          if (drain_done) begin
            state_q <= ST_IDLE;
            if (stop_seen_q) aborted <= 1'b1;
            else             done    <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase

      // Placed after the start clear so a simultaneous spurious strobe wins.
      if (gen_valid && !inflight_q) proto_err <= 1'b1;
    end
  end

endmodule
